// File: rtl/conv_pkg.sv
// Shared types, widths and helpers for the convolution product feeder.
package conv_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int ACC_W       = 32;
  localparam int MULT_CYCLES = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MULT,
    EMIT,
    DONE
  } FeederState;

  // Magnitude of a two's-complement operand; -32768 maps to 0x8000.
  function automatic logic [SAMPLE_W-1:0] magnitude(input logic [SAMPLE_W-1:0] value);
    return value[SAMPLE_W-1] ? ((~value) + SAMPLE_W'(1)) : value;
  endfunction

  // Product sign; a zero operand always yields a positive (zero) product.
  function automatic logic productNegative(input logic [SAMPLE_W-1:0] a,
                                           input logic [SAMPLE_W-1:0] b);
    return (a[SAMPLE_W-1] ^ b[SAMPLE_W-1]) && (a != '0) && (b != '0);
  endfunction

endpackage

// File: rtl/conv_product_feeder_if.sv
// Operand handshake and accumulator drive bundle for conv_product_feeder.
interface conv_product_feeder_if;
  import conv_pkg::*;

  logic [SAMPLE_W-1:0] Sample;
  logic [SAMPLE_W-1:0] Coeff;
  logic                LastTap;
  logic                InValid;
  logic                InReady;
  logic                Flush;
  logic [ACC_W-1:0]    AddIn;
  logic                SignBit;
  logic                AccumReset;
  logic                WindowDone;

  modport master (
    output Sample, Coeff, LastTap, InValid, Flush,
    input  InReady, AddIn, SignBit, AccumReset, WindowDone
  );

  modport slave (
    input  Sample, Coeff, LastTap, InValid, Flush,
    output InReady, AddIn, SignBit, AccumReset, WindowDone
  );

endinterface

// File: rtl/shift_add_mult16.sv
// 16x16 -> 32 unsigned shift-add multiplier. The first partial product is
// folded into the start cycle, so done rises MULT_CYCLES-1 edges after start
// and the product can be registered by the caller on the following edge.
module shift_add_mult16
  import conv_pkg::*;
(
  input  logic                clk,
  input  logic                ResetN,
  input  logic                start,
  input  logic [SAMPLE_W-1:0] multiplicand,
  input  logic [SAMPLE_W-1:0] multiplier,
  output logic                done,
  output logic [ACC_W-1:0]    product
);

  logic [ACC_W-1:0]    accReg;
  logic [ACC_W-1:0]    mcandReg;
  logic [SAMPLE_W-1:0] mplierReg;
  logic [4:0]          countReg;

  // Load with bit 0 already applied, then add one shifted partial product per cycle.
  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) begin
      accReg    <= '0;
      mcandReg  <= '0;
      mplierReg <= '0;
      countReg  <= '0;
    end else if (start) begin
      accReg    <= multiplier[0] ? {{(ACC_W-SAMPLE_W){1'b0}}, multiplicand} : '0;
      mcandReg  <= {{(ACC_W-SAMPLE_W-1){1'b0}}, multiplicand, 1'b0};
      mplierReg <= {1'b0, multiplier[SAMPLE_W-1:1]};
      countReg  <= 5'd1;
    end else if ((countReg != '0) && (countReg != 5'(MULT_CYCLES))) begin
      accReg    <= accReg + (mplierReg[0] ? mcandReg : '0);
      mcandReg  <= mcandReg << 1;
      mplierReg <= mplierReg >> 1;
      countReg  <= countReg + 5'd1;
    end
  end

  assign done    = (countReg == 5'(MULT_CYCLES));
  assign product = accReg;

endmodule

// File: rtl/conv_product_feeder.sv
// Feeds signed-magnitude tap products to a negedge accumulator, one window
// at a time. Optional macro CONV_FEEDER_FAST_MULT_EN swaps the 16-cycle
// shift-add multiplier for a single-cycle multiply.
module conv_product_feeder
  import conv_pkg::*;
(
  input  logic                 clk,
  input  logic                 ResetN,
  conv_product_feeder_if.slave bus
);

  FeederState          state;
  logic                windowOpen;
  logic                lastTapReg;
  logic                signReg;
  logic [SAMPLE_W-1:0] sampleMagReg;
  logic [SAMPLE_W-1:0] coeffMagReg;
  logic                inReadyReg;
  logic                accumResetReg;
  logic                windowDoneReg;
  logic                signBitReg;
  logic [ACC_W-1:0]    addInReg;

  logic                accept;
  logic                multDone;
  logic [ACC_W-1:0]    product;

  assign accept = bus.InValid && inReadyReg && (state == IDLE);

`ifdef CONV_FEEDER_FAST_MULT_EN
  assign product  = ACC_W'(sampleMagReg) * ACC_W'(coeffMagReg);
  assign multDone = 1'b1;
`else
  logic                multStart;
  logic [SAMPLE_W-1:0] multA;
  logic [SAMPLE_W-1:0] multB;

  // Multiplier starts on the edge that enters MULT: straight from the accept
  // edge (operands still on the bus) or from CLEAR (operands already captured).
  assign multStart = (accept && windowOpen) || (state == CLEAR);
  assign multA     = (state == IDLE) ? magnitude(bus.Sample) : sampleMagReg;
  assign multB     = (state == IDLE) ? magnitude(bus.Coeff)  : coeffMagReg;

  shift_add_mult16 uMult (
    .clk          (clk),
    .ResetN       (ResetN),
    .start        (multStart),
    .multiplicand (multA),
    .multiplier   (multB),
    .done         (multDone),
    .product      (product)
  );
`endif

  // Sequencer: handshake, window tracking and every registered output.
  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) begin
      state         <= IDLE;
      windowOpen    <= 1'b0;
      lastTapReg    <= 1'b0;
      signReg       <= 1'b0;
      sampleMagReg  <= '0;
      coeffMagReg   <= '0;
      inReadyReg    <= 1'b0;
      accumResetReg <= 1'b0;
      windowDoneReg <= 1'b0;
      signBitReg    <= 1'b0;
      addInReg      <= '0;
    end else begin
      // Outputs are pulses: idle values unless the next state says otherwise.
      accumResetReg <= 1'b0;
      windowDoneReg <= 1'b0;
      signBitReg    <= 1'b0;
      addInReg      <= '0;
      inReadyReg    <= 1'b0;
      if (bus.Flush) begin
        state      <= IDLE;
        windowOpen <= 1'b0;
        inReadyReg <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              sampleMagReg <= magnitude(bus.Sample);
              coeffMagReg  <= magnitude(bus.Coeff);
              signReg      <= productNegative(bus.Sample, bus.Coeff);
              lastTapReg   <= bus.LastTap;
              if (!windowOpen) begin
                state         <= CLEAR;
                windowOpen    <= 1'b1;
                accumResetReg <= 1'b1;
              end else begin
                state <= MULT;
              end
            end else begin
              inReadyReg <= 1'b1;
            end
          end
          CLEAR: state <= MULT;
          MULT: begin
            if (multDone) begin
              state      <= EMIT;
              addInReg   <= product;
              signBitReg <= signReg;
            end
          end
          EMIT: begin
            if (lastTapReg) begin
              state         <= DONE;
              windowDoneReg <= 1'b1;
            end else begin
              state      <= IDLE;
              inReadyReg <= 1'b1;
            end
          end
          DONE: begin
            state      <= IDLE;
            windowOpen <= 1'b0;
            inReadyReg <= 1'b1;
          end
          default: begin
            state      <= IDLE;
            windowOpen <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.InReady    = inReadyReg;
  assign bus.AccumReset = accumResetReg;
  assign bus.WindowDone = windowDoneReg;
  assign bus.SignBit    = signBitReg;
  assign bus.AddIn      = addInReg;

endmodule

// File: tb/tb_conv_product_feeder.sv
// Bench for conv_product_feeder: directed table, flush/reset sequences and
// random windows checked cycle by cycle against spec-level latencies and sums.
module tb_conv_product_feeder;

`ifdef CONV_FEEDER_FAST_MULT_EN
  localparam int MULT_LAT = 1;
`else
  localparam int MULT_LAT = 16;
`endif

  logic clk;
  logic ResetN;
  conv_product_feeder_if bus();

  conv_product_feeder dut (
    .clk    (clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int tapCount = 0;
  bit windowOpenModel = 1'b0;
  int windowSum = 0;

  // Environment accumulator: clears or adds the signed product every negedge.
  logic [31:0] accum = 32'd0;
  always @(negedge clk) begin
    if (bus.AccumReset) accum <= 32'd0;
    else if (bus.SignBit) accum <= accum - bus.AddIn;
    else accum <= accum + bus.AddIn;
  end

  typedef struct {
    logic signed [15:0] s;
    logic signed [15:0] c;
    bit                 last;
    logic [31:0]        expMag;
    bit                 expSign;
    logic [31:0]        expSum;
  } vec_t;

  vec_t vecs [0:8];

  function automatic logic [35:0] outVec();
    return {bus.InReady, bus.AccumReset, bus.WindowDone, bus.SignBit, bus.AddIn};
  endfunction

  task automatic checkVec(input string name, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got rdy=%b ar=%b wd=%b neg=%b add=%h want rdy=%b ar=%b wd=%b neg=%b add=%h",
               name, got[35], got[34], got[33], got[32], got[31:0],
               exp[35], exp[34], exp[33], exp[32], exp[31:0]);
    end
  endtask

  task automatic checkSum(input string name, input logic [31:0] exp);
    checks++;
    if (accum !== exp) begin
      errors++;
      $display("FAIL %s accumulator got %h want %h", name, accum, exp);
    end
  endtask

  function automatic void refProduct(input logic signed [15:0] s, input logic signed [15:0] c,
                                     output logic [31:0] mag, output bit neg);
    longint p;
    p = longint'(s) * longint'(c);
    neg = (p < 0);
    mag = neg ? 32'(-p) : 32'(p);
  endfunction

  function automatic logic [15:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Present one operand pair at a negedge; the feeder must already be ready.
  task automatic acceptTap(input logic signed [15:0] s, input logic signed [15:0] c,
                           input bit last, output bit ok);
    int waited;
    waited = 0;
    ok = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.InReady !== 1'b1) begin
      errors++;
      $display("FAIL ready_now got InReady=%b want 1", bus.InReady);
    end
    while (bus.InReady !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (bus.InReady !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got InReady=%b want 1 within 40 cycles", bus.InReady);
      return;
    end
    ok = 1'b1;
    bus.Sample  = s;
    bus.Coeff   = c;
    bus.LastTap = last;
    bus.InValid = 1'b1;
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
  endtask

  // One full tap: accept, then check every output in every cycle up to EMIT/DONE.
  task automatic doTap(input logic signed [15:0] s, input logic signed [15:0] c, input bit last,
                       input logic [31:0] expMag, input bit expSign);
    bit ok;
    bit clr;
    int emitCyc;
    int nCyc;
    bit eAr;
    bit eWd;
    bit eNeg;
    logic [31:0] eAdd;
    clr = !windowOpenModel;
    emitCyc = MULT_LAT + 1 + (clr ? 1 : 0);
    nCyc = emitCyc + (last ? 1 : 0);
    tapCount++;
    acceptTap(s, c, last, ok);
    if (!ok) return;
    if (clr) windowSum = 0;
    windowOpenModel = 1'b1;
    windowSum += int'(s) * int'(c);
    for (int k = 1; k <= nCyc; k++) begin
      @(negedge clk);
      eAr  = clr && (k == 1);
      eWd  = last && (k == emitCyc + 1);
      eNeg = (k == emitCyc) && expSign;
      eAdd = (k == emitCyc) ? expMag : 32'd0;
      checkVec($sformatf("tap%0d_cyc%0d", tapCount, k), outVec(), {1'b0, eAr, eWd, eNeg, eAdd});
    end
    if (last) begin
      checkSum($sformatf("tap%0d_window_sum", tapCount), 32'(windowSum));
      windowOpenModel = 1'b0;
    end
    $display("tap %0d s=%0d c=%0d last=%0d clear=%0d mag=%0d neg=%0d acc=%0d",
             tapCount, s, c, last, clr, expMag, expSign, $signed(accum));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int flushAt;
    int rstAt;
    int nTaps;
    logic [15:0] rs;
    logic [15:0] rc;
    logic [31:0] rMag;
    bit rNeg;

    vecs[0] = '{16'sd3,      -16'sd4,     1'b1, 32'd12,         1'b1, 32'hFFFFFFF4};
    vecs[1] = '{16'sd100,    16'sd2,      1'b0, 32'd200,        1'b0, 32'd0};
    vecs[2] = '{-16'sd5,     -16'sd5,     1'b0, 32'd25,         1'b0, 32'd0};
    vecs[3] = '{16'sd7,      -16'sd1,     1'b1, 32'd7,          1'b1, 32'd218};
    vecs[4] = '{-16'sd32768, -16'sd32768, 1'b1, 32'h40000000,   1'b0, 32'h40000000};
    vecs[5] = '{16'sd0,      -16'sd9,     1'b1, 32'd0,          1'b0, 32'd0};
    vecs[6] = '{-16'sd32768, 16'sd32767,  1'b1, 32'd1073709056, 1'b1, 32'hC0008000};
    vecs[7] = '{16'sd32767,  16'sd32767,  1'b0, 32'd1073676289, 1'b0, 32'd0};
    vecs[8] = '{-16'sd1,     -16'sd1,     1'b1, 32'd1,          1'b0, 32'h3FFF0002};

    ResetN      = 1'b0;
    bus.Sample  = '0;
    bus.Coeff   = '0;
    bus.LastTap = 1'b0;
    bus.InValid = 1'b0;
    bus.Flush   = 1'b0;

    // Reset state and release
    @(negedge clk);
    @(negedge clk);
    checkVec("reset_state", outVec(), 36'd0);
    ResetN = 1'b1;
    #1;
    checkVec("reset_release", outVec(), 36'd0);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      doTap(vecs[i].s, vecs[i].c, vecs[i].last, vecs[i].expMag, vecs[i].expSign);
      if (vecs[i].last) checkSum($sformatf("table%0d_sum", i), vecs[i].expSum);
    end

    // Flush mid-MULT together with InValid
    doTap(16'sd11, 16'sd3, 1'b0, 32'd33, 1'b0);
    acceptTap(-16'sd7, 16'sd9, 1'b0, ok);
    flushAt = (MULT_LAT > 4) ? 4 : 1;
    for (int k = 1; k <= flushAt; k++) begin
      @(negedge clk);
      checkVec($sformatf("flush_mult_cyc%0d", k), outVec(), 36'd0);
    end
    bus.Flush   = 1'b1;
    bus.InValid = 1'b1;
    bus.Sample  = 16'sd21;
    bus.Coeff   = 16'sd2;
    bus.LastTap = 1'b1;
    @(posedge clk);
    #1;
    bus.Flush   = 1'b0;
    bus.InValid = 1'b0;
    windowOpenModel = 1'b0;
    for (int k = 1; k <= MULT_LAT + 4; k++) begin
      @(negedge clk);
      checkVec($sformatf("flush_idle_cyc%0d", k), outVec(), {1'b1, 35'd0});
    end
    $display("flush sequence done");
    doTap(16'sd21, 16'sd2, 1'b1, 32'd42, 1'b0);

    // Reset mid-MULT inside an open window
    doTap(16'sd5, 16'sd5, 1'b0, 32'd25, 1'b0);
    acceptTap(16'sd9, 16'sd9, 1'b0, ok);
    rstAt = (MULT_LAT > 8) ? 8 : 1;
    repeat (rstAt) @(negedge clk);
    #2 ResetN = 1'b0;
    #1 checkVec("rst_async_mult", outVec(), 36'd0);
    windowOpenModel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkVec("rst_held", outVec(), 36'd0);
    ResetN = 1'b1;
    #1 checkVec("rst_release2", outVec(), 36'd0);
    $display("reset sequence done");
    doTap(-16'sd3, 16'sd8, 1'b1, 32'd24, 1'b1);

    // Random windows against the arithmetic model
    for (int w = 0; w < 20; w++) begin
      nTaps = $urandom_range(1, 4);
      for (int t = 0; t < nTaps; t++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rs = pickOperand();
        rc = pickOperand();
        refProduct(rs, rc, rMag, rNeg);
        doTap(rs, rc, (t == nTaps - 1), rMag, rNeg);
      end
    end

    // Reset is asynchronous even while idle
    @(negedge clk);
    checkVec("idle_ready", outVec(), {1'b1, 35'd0});
    #2 ResetN = 1'b0;
    #1 checkVec("rst_async_idle", outVec(), 36'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_product_feeder.md
CONV_PRODUCT_FEEDER -- requirements
Module: conv_product_feeder

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on posedge.
REQ-002 SHALL have ports: ResetN  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: Sample  in  16  two's-complement input sample.
REQ-004 SHALL have ports: Coeff  in  16  two's-complement kernel coefficient.
REQ-005 SHALL have ports: LastTap  in  1  marks final tap of the current output window.
REQ-006 SHALL have ports: InValid  in  1  operand pair valid.
REQ-007 SHALL have ports: InReady  out  1  feeder can accept an operand pair.
REQ-008 SHALL have ports: Flush  in  1  synchronous abort of the current window.
REQ-009 SHALL have ports: AddIn  out  32  product magnitude driven to the accumulator.
REQ-010 SHALL have ports: SignBit  out  1  product sign (1 = negative).
REQ-011 SHALL have ports: AccumReset  out  1  clears the accumulator.
REQ-012 SHALL have ports: WindowDone  out  1  one-cycle pulse; accumulator holds the final window sum.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, MULT, EMIT, DONE; all outputs registered and changed only on posedge, so they are stable at the accumulator's negedge.
REQ-014 SHALL assert InReady only in IDLE; accept when InValid && InReady at a posedge, capturing Sample, Coeff, LastTap.
REQ-015 SHALL keep an internal WindowOpen flag; on accept with WindowOpen=0 go to CLEAR and set WindowOpen, otherwise go to MULT.
REQ-016 SHALL assert AccumReset=1 for exactly the one CLEAR cycle, then go to MULT.
REQ-017 SHALL multiply operand magnitudes unsigned (|-32768| = 32768); 32-bit product, no overflow possible (max 2^30).
REQ-018 SHALL set SignBit = Sample[15] ^ Coeff[15], forced to 0 when either operand is zero.
REQ-019 SHALL drive AddIn=product and SignBit for exactly one EMIT cycle; AddIn=0 and SignBit=0 in every other cycle (the accumulator adds every negedge).
REQ-020 SHALL go from EMIT to DONE if the captured LastTap=1, else to IDLE.
REQ-021 SHALL pulse WindowDone=1 for the single DONE cycle, clear WindowOpen, and return to IDLE.
REQ-022 SHALL, on Flush=1 at a posedge in any state, go to IDLE, clear WindowOpen, and emit nothing; Flush wins over a simultaneous InValid (no accept).
REQ-023 SHALL sustain back-to-back taps: a tap can be accepted in the cycle after EMIT or DONE.

Reset
REQ-024 SHALL on ResetN=0, independent of clk, force state IDLE, WindowOpen=0, AddIn=0, SignBit=0, AccumReset=0, WindowDone=0, InReady=0; InReady rises in the first cycle after reset release.
REQ-025 SHALL discard an operation interrupted by reset mid-MULT, and SHALL start the next accepted tap with CLEAR.

Configuration
REQ-026 SHALL support macro CONV_FEEDER_FAST_MULT_EN: when defined, MULT lasts 1 cycle using a single-cycle multiplier; EMIT is the 2nd cycle after the accepting edge (3rd with CLEAR).
REQ-027 SHALL, with CONV_FEEDER_FAST_MULT_EN undefined, perform 16-cycle shift-add in MULT; EMIT is the 17th cycle after the accepting edge (18th with CLEAR).

Structure
REQ-028 SHALL place the state enum and constants SAMPLE_W=16, ACC_W=32, MULT_CYCLES=16 in shared package conv_pkg.
REQ-029 SHALL implement the sequential multiplier as sub-module shift_add_mult16 (start, done, 16x16->32 unsigned).

Verification
REQ-030 SHALL verify: first tap Sample=3, Coeff=-4, LastTap=1 -> AccumReset 1 cycle, EMIT AddIn=12 SignBit=1 at cycle 18, WindowDone next cycle, accumulator reads -12 (0xFFFFFFF4).
REQ-031 SHALL verify: three taps (100,2),(-5,-5),(7,-1) last on third -> single AccumReset, sum 218 at WindowDone.
REQ-032 SHALL verify: Sample=-32768, Coeff=-32768 -> AddIn=0x40000000, SignBit=0.
REQ-033 SHALL verify: Sample=0, Coeff=-9 -> AddIn=0, SignBit=0; AddIn=0 in all non-EMIT cycles.
REQ-034 SHALL verify: Flush asserted mid-MULT together with InValid -> no EMIT, no accept that cycle; next tap begins with AccumReset.
REQ-035 SHALL verify: ResetN low at MULT cycle 8 -> all outputs 0 immediately; after release, first tap is preceded by CLEAR; repeat under CONV_FEEDER_FAST_MULT_EN with EMIT at cycle 2/3.
